keypad_scanner: RTL and testbench

Input-side counterpart to the multiplexed 4-digit display driver. That driver strobes one digit line at a time and drives segments. This block strobes one column of a 4x4 matrix keypad at a time, reads the row lines back, and debounces the result. It emits a 4-bit hex key code with a one-cycle press strobe, for consumption by the display/counter logic in top.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/sync_ff2.sv | 36 +++
 rtl/keypad_scanner.sv | 187 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner.
//   NUM_COLS / NUM_ROWS : keypad matrix geometry.
//   frame_res_t         : per-frame scan result {hit, code}; KEY_NONE means
//                         "no single key seen" (idle, ghosting or multi-press).
//   key_code()          : maps a (row, col) position to its hex key code.
//   key_hit()           : builds a frame result carrying a valid key code.
// -----------------------------------------------------------------------------
package keypad_pkg;

   localparam int NUM_COLS = 4;
   localparam int NUM_ROWS = 4;

   typedef struct packed {
      logic       hit;
      logic [3:0] code;
   } frame_res_t;

   localparam frame_res_t KEY_NONE = frame_res_t'(5'b0_0000);

   // Key code is row*4 + col, which for a 4x4 matrix is just {row, col}.
   function automatic logic [3:0] key_code(input logic [1:0] row,
                                           input logic [1:0] col);
      return {row, col};
   endfunction

   function automatic frame_res_t key_hit(input logic [3:0] code);
      frame_res_t res;
      res.hit  = 1'b1;
      res.code = code;
      return res;
   endfunction

endpackage

// File: rtl/sync_ff2.sv
// -----------------------------------------------------------------------------
// sync_ff2
// Generic two-flop synchronizer for asynchronous level inputs.
// Resets to all-ones so that idle, pulled-up active-low lines read inactive.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input bus
//   q     : synchronized output bus (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_ff2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values; a blocking = here would collapse the two stages into one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, reads the rows
// back through a synchronizer, classifies each full frame (4 columns) as a
// single key or NONE, and debounces frame results before accepting a key.
//   CLK       : system clock
//   RST_N     : asynchronous active-low reset
//   col_n     : column drives, active-low, exactly one column low
//   rows_n    : row sense lines, active-low, asynchronous (pulled up)
//   key       : last accepted key code (row*4 + col)
//   key_valid : one-cycle pulse when a new key is accepted
//   key_held  : high while an accepted key remains held
// Parameters:
//   SCAN_DIV  : clocks each column is driven before its rows are sampled (>=4)
//   DEBOUNCE  : identical consecutive frames needed to change the accepted
//               state (>=1)
// -----------------------------------------------------------------------------
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 1024,
   parameter int DEBOUNCE = 40
) (
   input  logic                CLK,
   input  logic                RST_N,
   output logic [NUM_COLS-1:0] col_n,
   input  logic [NUM_ROWS-1:0] rows_n,
   output logic [3:0]          key,
   output logic                key_valid,
   output logic                key_held
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int STB_W = $clog2(DEBOUNCE + 1);

   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [STB_W-1:0]    STB_MAX  = STB_W'(DEBOUNCE);
   localparam logic [1:0]          COL_LAST = 2'(NUM_COLS - 1);
   localparam logic [NUM_COLS-1:0] COL0_N   = ~NUM_COLS'(1);

   // ---------------------------------------------------------------------------
   // Row synchronizer
   // ---------------------------------------------------------------------------
   logic [NUM_ROWS-1:0] rows_sync;

   sync_ff2 #(
      .WIDTH (NUM_ROWS)
   ) u_rows_sync (
      .clk   (CLK),
      .rst_n (RST_N),
      .d     (rows_n),
      .q     (rows_sync)
   );

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [DIV_W-1:0]    div_q,      div_d;
   logic [1:0]          col_q,      col_d;
   logic [NUM_COLS-1:0] col_n_q,    col_n_d;
   logic [1:0]          hits_q,     hits_d;      // pressed bits this frame, saturates at 2
   logic [3:0]          code_q,     code_d;      // code of the last single hit this frame
   frame_res_t          prev_q,     prev_d;
   logic [STB_W-1:0]    stable_q,   stable_d;
   frame_res_t          accepted_q, accepted_d;
   logic [3:0]          key_q,      key_d;
   logic                key_valid_q, key_valid_d;
   logic                key_held_q,  key_held_d;

   // ---------------------------------------------------------------------------
   // Combinational scan / classify / debounce
   // ---------------------------------------------------------------------------
   logic [NUM_ROWS-1:0] pressed;
   logic [2:0]          col_hits;
   logic [1:0]          row_idx;
   logic                sample;
   logic                frame_end;
   logic [1:0]          base_hits;
   logic [3:0]          base_code;
   logic [2:0]          total_hits;
   logic [1:0]          new_hits;
   logic [3:0]          new_code;
   frame_res_t          frame_res;

   // NOTE: every signal written here gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      pressed  = ~rows_sync;
      col_hits = '0;
      row_idx  = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (pressed[r]) begin
            col_hits = col_hits + 3'd1;
            row_idx  = 2'(r);
         end
      end

      sample    = (div_q == DIV_LAST);
      frame_end = sample && (col_q == COL_LAST);

      // Column 0 opens a new frame, so it ignores whatever was accumulated.
      base_hits  = (col_q == 2'd0) ? 2'd0 : hits_q;
      base_code  = (col_q == 2'd0) ? 4'd0 : code_q;
      total_hits = {1'b0, base_hits} + col_hits;
      new_hits   = (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
      new_code   = (col_hits == 3'd1) ? key_code(row_idx, col_q) : base_code;
      frame_res  = (new_hits == 2'd1) ? key_hit(new_code) : KEY_NONE;

      div_d       = div_q + 1'b1;
      col_d       = col_q;
      col_n_d     = col_n_q;
      hits_d      = hits_q;
      code_d      = code_q;
      prev_d      = prev_q;
      stable_d    = stable_q;
      accepted_d  = accepted_q;
      key_d       = key_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;

      if (sample) begin
         div_d   = '0;
         col_d   = col_q + 2'd1;
         col_n_d = ~(NUM_COLS'(1) << col_d);
         hits_d  = new_hits;
         code_d  = new_code;
      end

      if (frame_end) begin
         if (frame_res == prev_q) begin
            stable_d = (stable_q == STB_MAX) ? stable_q : stable_q + 1'b1;
         end else begin
            stable_d = STB_W'(1);
            prev_d   = frame_res;
         end

         if ((stable_d == STB_MAX) && (frame_res != accepted_q)) begin
            accepted_d = frame_res;
            if (frame_res.hit) begin
               key_d       = frame_res.code;
               key_held_d  = 1'b1;
               key_valid_d = 1'b1;
            end else begin
               key_held_d  = 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         div_q       <= '0;
         col_q       <= '0;
         col_n_q     <= COL0_N;
         hits_q      <= '0;
         code_q      <= '0;
         prev_q      <= KEY_NONE;
         stable_q    <= '0;
         accepted_q  <= KEY_NONE;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         div_q       <= div_d;
         col_q       <= col_d;
         col_n_q     <= col_n_d;
         hits_q      <= hits_d;
         code_q      <= code_d;
         prev_q      <= prev_d;
         stable_q    <= stable_d;
         accepted_q  <= accepted_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   // Column drive comes straight from a flop so only one line ever moves low.
   assign col_n     = col_n_q;
   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3.
// A keypad model pulls row r low while key (r,c) is pressed and column c is
// driven. Stimulus is a pressed-key mask held for whole frames; a frame-level
// reference model classifies each mask and debounces the results.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 3;
   localparam int FRAME    = 4 * SCAN_DIV;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic [3:0] col_n;
   logic [3:0] rows_n;
   logic [3:0] key;
   logic       key_valid;
   logic       key_held;

   logic [15:0] pressed = '0;   // bit index = row*4 + col = key code

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state (-1 stands for NONE)
   int m_prev;
   int m_stable;
   int m_acc;
   int m_key;
   int m_held;

   keypad_scanner #(
      .SCAN_DIV (SCAN_DIV),
      .DEBOUNCE (DEBOUNCE)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .col_n     (col_n),
      .rows_n    (rows_n),
      .key       (key),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 CLK = ~CLK;

   // Keypad matrix model
   always_comb begin
      rows_n = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (col_n[c] == 1'b0 && pressed[r*4 + c]) rows_n[r] = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_prev   = -1;
      m_stable = 0;
      m_acc    = -1;
      m_key    = 0;
      m_held   = 0;
   endtask

   // A frame names a key only when exactly one key is down.
   function automatic int frame_result(input logic [15:0] m);
      if ($countones(m) == 1) begin
         for (int i = 0; i < 16; i++) if (m[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_frame(input int res, output int pulse);
      pulse = 0;
      if (res == m_prev) begin
         if (m_stable < DEBOUNCE) m_stable++;
      end else begin
         m_stable = 1;
         m_prev   = res;
      end
      if (m_stable == DEBOUNCE && res != m_acc) begin
         m_acc = res;
         if (res >= 0) begin
            m_key  = res;
            m_held = 1;
            pulse  = 1;
         end else begin
            m_held = 0;
         end
      end
   endtask

   // Entered at the negedge inside the first cycle of a frame; returns at the
   // negedge inside the first cycle of the next frame, which also carries the
   // output update from this frame's evaluation.
   task automatic run_frame(input logic [15:0] mask);
      int         pulses;
      int         exp_pulse;
      logic [3:0] exp_col;
      pulses  = 0;
      pressed = mask;
      for (int j = 1; j <= FRAME; j++) begin
         @(negedge CLK);
         if (key_valid !== 1'b0) pulses++;
         if (j % SCAN_DIV == 0) begin
            exp_col = ~(4'b0001 << ((j / SCAN_DIV) % 4));
            check("col_n", col_n, exp_col);
         end
      end
      model_frame(frame_result(mask), exp_pulse);
      check("key_valid_cycles", pulses, exp_pulse);
      check("key", key, m_key);
      check("key_held", key_held, m_held);
   endtask

   task automatic check_reset_outputs();
      check("rst_col_n", col_n, 4'b1110);
      check("rst_key", key, 4'd0);
      check("rst_key_valid", key_valid, 1'b0);
      check("rst_key_held", key_held, 1'b0);
   endtask

   // Runs part of a frame, then asserts reset between clock edges.
   task automatic reset_mid(input logic [15:0] mask, input int cycles);
      pressed = mask;
      repeat (cycles) @(negedge CLK);
      #2 RST_N = 1'b0;
      #1 check_reset_outputs();
      repeat (3) @(negedge CLK);
      check_reset_outputs();
      RST_N = 1'b1;
      model_reset();
   endtask

   initial begin
      int          kind;
      int          a;
      int          b;
      int          hold;
      logic [15:0] m;

      // Case 1: reset, no key
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      check_reset_outputs();
      RST_N = 1'b1;
      model_reset();
      repeat (3) run_frame(16'h0000);

      // Case 2: press (2,1) = key 9 and hold for well beyond acceptance
      repeat (24) run_frame(16'h0001 << 9);

      // Case 3: release
      repeat (5) run_frame(16'h0000);

      // Case 4: bounce key (0,0) every frame, then hold
      for (int i = 0; i < 10; i++) run_frame((i % 2 == 0) ? 16'h0001 : 16'h0000);
      repeat (5) run_frame(16'h0001);
      repeat (4) run_frame(16'h0000);

      // Case 5: ghosting pair (0,3)+(3,0), then keep only (0,3)
      repeat (5) run_frame((16'h0001 << 3) | (16'h0001 << 12));
      repeat (5) run_frame(16'h0001 << 3);

      // Direct KEY->KEY change
      repeat (4) run_frame(16'h0001 << 6);

      // Case 6: reset mid-debounce of key 15, then clean restart
      repeat (2) run_frame(16'h0001 << 15);
      reset_mid(16'h0001 << 15, 5);
      repeat (5) run_frame(16'h0001 << 15);
      repeat (4) run_frame(16'h0000);

      // Randomized phase: idle, single keys and key pairs with random durations
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 3);
         a    = $urandom_range(0, 15);
         b    = (a + $urandom_range(1, 15)) % 16;
         hold = $urandom_range(1, 5);
         case (kind)
            0:       m = 16'h0000;
            3:       m = (16'h0001 << a) | (16'h0001 << b);
            default: m = 16'h0001 << a;
         endcase
         repeat (hold) run_frame(m);
      end
      repeat (4) run_frame(16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
